dmem_lsu: RTL and testbench

Load/store unit between the decoded memory control signals (`D_MEM_read`, `D_MEM_write`, `D_MEM_mode`) in the MEM stage and a word-organised data SRAM port with a req/gnt/rvalid handshake. It responds to each memory instruction by generating byte enables and lane-aligned write data. Misaligned accesses are split into two word transactions. Load data is returned sign- or zero-extended. The pipeline is stalled until the access completes.

---
 rtl/dmem_lsu.sv | 226 ++++++++++++++++++++++
 tb/tb_dmem_lsu.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// dmem_lsu: MEM-stage load/store unit driving a word SRAM port.
// Misaligned accesses become two word transactions; stalls until done.
module dmem_lsu #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  D_MEM_read,
  input  logic                  D_MEM_write,
  input  logic [1:0]            D_MEM_mode,
  input  logic                  load_unsigned,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  stall,
  output logic                  done,
  output logic [31:0]           rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata
);
  localparam int WA = ADDR_WIDTH - 2;

  typedef enum logic [2:0] {
    IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, DONE
  } state_t;

  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0] mode_q, mode_d;
  logic uns_q, uns_d;
  logic we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] rdata_q, rdata_d;
  logic mem_req_q, mem_req_d;
  logic mem_we_q, mem_we_d;
  logic [WA-1:0] mem_addr_q, mem_addr_d;
  logic [3:0] mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic split_r;
  logic [WA-1:0] hi_addr;
  logic [3:0] hi_be;
  logic [31:0] hi_wdata;

  function automatic logic [3:0] mask_of(
    input logic [1:0] m
  );
    unique case (m)
      2'd0:    mask_of = 4'h1;
      2'd1:    mask_of = 4'h3;
      default: mask_of = 4'hF;
    endcase
  endfunction

  function automatic logic is_split(
    input logic [1:0] off,
    input logic [1:0] m
  );
    unique case (m)
      2'd0:    is_split = 1'b0;
      2'd1:    is_split = (off == 2'd3);
      default: is_split = (off != 2'd0);
    endcase
  endfunction

  function automatic logic [31:0] extend(
    input logic [63:0] hl,
    input logic [1:0]  off,
    input logic [1:0]  m,
    input logic        u
  );
    logic [31:0] v;
    v = 32'(hl >> {off, 3'b000});
    unique case (m)
      2'd0:    extend = {{24{v[7] & ~u}}, v[7:0]};
      2'd1:    extend = {{16{v[15] & ~u}}, v[15:0]};
      default: extend = v;
    endcase
  endfunction

  // Upper-word lanes carry the bytes that spilled past lane 3.
  always_comb begin
    split_r  = is_split(addr_q[1:0], mode_q);
    hi_addr  = addr_q[ADDR_WIDTH-1:2] + WA'(1);
    hi_be    = mask_of(mode_q)
               >> (3'd4 - {1'b0, addr_q[1:0]});
    hi_wdata = wdata_q
               >> (6'd32 - {1'b0, addr_q[1:0], 3'b000});
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    mode_d      = mode_q;
    uns_d       = uns_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    lo_d        = lo_q;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (D_MEM_read || D_MEM_write) begin
          state_d     = REQ_LO;
          addr_d      = addr;
          mode_d      = D_MEM_mode;
          uns_d       = load_unsigned;
          we_d        = D_MEM_write;
          wdata_d     = wdata;
          mem_req_d   = 1'b1;
          mem_we_d    = D_MEM_write;
          mem_addr_d  = addr[ADDR_WIDTH-1:2];
          mem_be_d    = mask_of(D_MEM_mode) << addr[1:0];
          mem_wdata_d = wdata << {addr[1:0], 3'b000};
        end
      end
      REQ_LO: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!we_q) begin
            state_d = WAIT_LO;
          end else if (split_r) begin
            state_d     = REQ_HI;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = hi_addr;
            mem_be_d    = hi_be;
            mem_wdata_d = hi_wdata;
          end else begin
            state_d = DONE;
          end
        end
      end
      WAIT_LO: begin
        if (mem_rvalid) begin
          lo_d = mem_rdata;
          if (split_r) begin
            state_d     = REQ_HI;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = hi_addr;
            mem_be_d    = hi_be;
            mem_wdata_d = hi_wdata;
          end else begin
            state_d = DONE;
            rdata_d = extend({32'h0, mem_rdata},
                             addr_q[1:0], mode_q, uns_q);
          end
        end
      end
      REQ_HI: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = we_q ? DONE : WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (mem_rvalid) begin
          state_d = DONE;
          rdata_d = extend({mem_rdata, lo_q},
                           addr_q[1:0], mode_q, uns_q);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      mode_q      <= '0;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      lo_q        <= '0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      mode_q      <= mode_d;
      uns_q       <= uns_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      lo_q        <= lo_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign stall = ((state_q == IDLE) && (D_MEM_read || D_MEM_write))
               || ((state_q != IDLE) && (state_q != DONE));
  assign done      = (state_q == DONE);
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: randomized and directed checks of dmem_lsu against a
// byte-level memory model and an SRAM responder with gnt/rvalid delays.
module tb_dmem_lsu;
  logic clk = 1'b0;
  logic rst;
  logic rd, wr, uns;
  logic [1:0] mode;
  logic [31:0] addr, wdata;
  logic stall, done;
  logic [31:0] rdata;
  logic mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [3:0] mem_be;
  logic [31:0] mem_wdata;
  logic mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .D_MEM_read(rd), .D_MEM_write(wr),
    .D_MEM_mode(mode), .load_unsigned(uns),
    .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic        we;
    logic [29:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } tx_t;

  logic [31:0] sram [logic [29:0]];
  logic [7:0]  refm [logic [31:0]];
  tx_t txq[$];
  tx_t expq[$];
  int gnt_wait = 0;
  int rv_lat = 1;
  int wcnt = 0;
  int rv_cnt = 0;
  logic [31:0] rv_data;

  function automatic logic [31:0] sram_rd(input logic [29:0] a);
    return sram.exists(a) ? sram[a] : 32'h0;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : 8'h0;
  endfunction

  function automatic int sz(input logic [1:0] m);
    return (m == 2'd0) ? 1 : ((m == 2'd1) ? 2 : 4);
  endfunction

  function automatic logic [31:0] ref_load(
    input logic [31:0] a, input logic [1:0] m, input logic u);
    logic [31:0] v;
    int n;
    v = 32'h0;
    n = sz(m);
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_rd(a + i);
    if (n < 4 && !u && v[8*n-1])
      for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic set_word(input logic [29:0] wa, input logic [31:0] v);
    sram[wa] = v;
    for (int i = 0; i < 4; i++) refm[{wa, 2'b00} + i] = v[8*i +: 8];
  endtask

  // Expected SRAM traffic: group the touched bytes by word address.
  task automatic build_exp(input logic w, input logic [31:0] a,
                           input logic [1:0] m, input logic [31:0] wd);
    tx_t t;
    bit have;
    logic [31:0] ba;
    have = 0;
    t = '0;
    expq.delete();
    for (int i = 0; i < sz(m); i++) begin
      ba = a + i;
      if (have && t.a != ba[31:2]) begin
        expq.push_back(t);
        have = 0;
      end
      if (!have) begin
        t = '0;
        t.we = w;
        t.a = ba[31:2];
        have = 1;
      end
      t.be[ba[1:0]] = 1'b1;
      t.d[8*ba[1:0] +: 8] = wd[8*i +: 8];
    end
    if (have) expq.push_back(t);
  endtask

  initial begin
    logic [31:0] w;
    mem_gnt = 0;
    mem_rvalid = 0;
    mem_rdata = 0;
    forever begin
      @(negedge clk);
      mem_rvalid = 0;
      mem_gnt = 0;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          mem_rvalid = 1;
          mem_rdata = rv_data;
        end
      end
      if (mem_req && !rst) begin
        if (wcnt >= gnt_wait) begin
          mem_gnt = 1;
          wcnt = 0;
          txq.push_back({mem_we, mem_addr, mem_be, mem_wdata});
          if (mem_we) begin
            w = sram_rd(mem_addr);
            for (int b = 0; b < 4; b++)
              if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            sram[mem_addr] = w;
          end else begin
            rv_cnt = rv_lat;
            rv_data = sram_rd(mem_addr);
          end
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Issue one instruction at posedge+1 and check the whole access.
  task automatic run_op(input logic r, input logic w,
                        input logic [1:0] m, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int g, input int rl, input string nm);
    int cyc, nreq, exp_cyc;
    bit got, sbad, unst, tbad;
    logic preq;
    logic [29:0] pa;
    logic [3:0] pb;
    logic [31:0] pd, exp_rd, dm;
    tx_t e, o;
    gnt_wait = g;
    rv_lat = rl;
    txq.delete();
    build_exp(w, a, m, wd);
    exp_rd = w ? rdata : ref_load(a, m, u);
    nreq = expq.size();
    exp_cyc = 1 + nreq * (1 + g) + (w ? 0 : nreq * rl);
    rd = r; wr = w; mode = m; uns = u; addr = a; wdata = wd;
    #1;
    sbad = (stall !== 1'b1);
    cyc = 0; got = 0; unst = 0; preq = 0;
    pa = '0; pb = '0; pd = '0;
    while (!got && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (preq && !mem_gnt &&
          (mem_req !== 1'b1 || mem_addr !== pa ||
           mem_be !== pb || mem_wdata !== pd)) unst = 1;
      preq = mem_req; pa = mem_addr; pb = mem_be; pd = mem_wdata;
      if (done === 1'b1) begin
        got = 1;
        if (stall !== 1'b0) sbad = 1;
      end else if (stall !== 1'b1) begin
        sbad = 1;
      end
    end
    n_cmp++;
    if (!got || cyc != exp_cyc) begin
      n_bad++;
      $display("FAIL %s latency: got %0d cycles (done=%0b), want %0d",
               nm, cyc, got, exp_cyc);
    end
    n_cmp++;
    if (sbad) begin
      n_bad++;
      $display("FAIL %s stall: stall not high until done, low in done", nm);
    end
    n_cmp++;
    if (unst) begin
      n_bad++;
      $display("FAIL %s stable: mem_* changed while waiting for gnt", nm);
    end
    n_cmp++;
    if (rdata !== exp_rd) begin
      n_bad++;
      $display("FAIL %s rdata: got %h, want %h", nm, rdata, exp_rd);
    end
    tbad = (txq.size() != expq.size());
    if (!tbad) begin
      foreach (expq[i]) begin
        e = expq[i];
        o = txq[i];
        dm = {{8{e.be[3]}}, {8{e.be[2]}}, {8{e.be[1]}}, {8{e.be[0]}}};
        if (o.we !== e.we || o.a !== e.a) tbad = 1;
        if ((w || sz(m) == 4) && o.be !== e.be) tbad = 1;
        if (w && ((o.d ^ e.d) & dm) !== 32'h0) tbad = 1;
      end
    end
    n_cmp++;
    if (tbad) begin
      n_bad++;
      $display("FAIL %s txns: got %0d first=%h, want %0d first=%h", nm,
               txq.size(), (txq.size() > 0) ? txq[0] : '0,
               expq.size(), (expq.size() > 0) ? expq[0] : '0);
    end
    if (w)
      for (int i = 0; i < sz(m); i++) refm[a + i] = wd[8*i +: 8];
    @(posedge clk);
    #1;
    rd = 0; wr = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    rd = 0; wr = 0; mode = 0; uns = 0; addr = 0; wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({stall, done, mem_req, mem_we} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset ctrl: got %b, want 0000",
               {stall, done, mem_req, mem_we});
    end
    n_cmp++;
    if (mem_addr !== 30'h0 || mem_be !== 4'h0) begin
      n_bad++;
      $display("FAIL reset addr/be: got %h/%h, want 0/0", mem_addr, mem_be);
    end
    n_cmp++;
    if (mem_wdata !== 32'h0 || rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset data: got %h/%h, want 0/0", mem_wdata, rdata);
    end
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_aligned_lw;
    set_word(30'h40, 32'h89ABCDEF);
    run_op(1, 0, 2'd2, 0, 32'h100, 32'h0, 0, 1, "lw");
    n_cmp++;
    if (rdata !== 32'h89ABCDEF) begin
      n_bad++;
      $display("FAIL lw const: got %h, want 89abcdef", rdata);
    end
  endtask

  task automatic test_lb_lbu;
    set_word(30'h40, 32'h80FFFFFF);
    run_op(1, 0, 2'd0, 0, 32'h103, 32'h0, 0, 1, "lb");
    n_cmp++;
    if (rdata !== 32'hFFFFFF80) begin
      n_bad++;
      $display("FAIL lb const: got %h, want ffffff80", rdata);
    end
    run_op(1, 0, 2'd0, 1, 32'h103, 32'h0, 0, 1, "lbu");
    n_cmp++;
    if (rdata !== 32'h00000080) begin
      n_bad++;
      $display("FAIL lbu const: got %h, want 00000080", rdata);
    end
  endtask

  task automatic test_split_sw;
    run_op(0, 1, 2'd2, 0, 32'h201, 32'h11223344, 0, 1, "split_sw");
    n_cmp++;
    if (txq.size() != 2 ||
        txq[0] !== {1'b1, 30'h80, 4'hE, 32'h22334400} ||
        txq[1] !== {1'b1, 30'h81, 4'h1, 32'h00000011}) begin
      n_bad++;
      $display("FAIL split_sw const: got %0d txns %h, want 2 fixed",
               txq.size(), (txq.size() > 0) ? txq[0] : '0);
    end
  endtask

  task automatic test_split_lh;
    set_word(30'h1, 32'hAB000000);
    set_word(30'h2, 32'h000000CD);
    run_op(1, 0, 2'd1, 0, 32'h7, 32'h0, 0, 1, "split_lh");
    n_cmp++;
    if (rdata !== 32'hFFFFCDAB) begin
      n_bad++;
      $display("FAIL split_lh const: got %h, want ffffcdab", rdata);
    end
    run_op(1, 0, 2'd1, 1, 32'h7, 32'h0, 0, 2, "split_lhu");
    n_cmp++;
    if (rdata !== 32'h0000CDAB) begin
      n_bad++;
      $display("FAIL split_lhu const: got %h, want 0000cdab", rdata);
    end
  endtask

  task automatic test_backpressure;
    run_op(0, 1, 2'd0, 0, 32'h302, 32'h5A5A_5AC3, 3, 1, "bp_sb");
    n_cmp++;
    if (txq.size() != 1 || txq[0].be !== 4'h4 ||
        txq[0].d[23:16] !== 8'hC3) begin
      n_bad++;
      $display("FAIL bp_sb lane: got %0d txns %h, want be 4 byte c3",
               txq.size(), (txq.size() > 0) ? txq[0] : '0);
    end
    run_op(1, 0, 2'd0, 1, 32'h302, 32'h0, 2, 1, "bp_lbu");
  endtask

  task automatic test_wrap;
    set_word(30'h3FFFFFFF, 32'h4433_2211);
    set_word(30'h0, 32'h8877_6655);
    run_op(1, 0, 2'd2, 0, 32'hFFFF_FFFE, 32'h0, 0, 1, "wrap_lw");
    run_op(0, 1, 2'd1, 0, 32'hFFFF_FFFF, 32'hABCD_BEEF, 1, 1, "wrap_sh");
    run_op(1, 0, 2'd3, 0, 32'hFFFF_FFFD, 32'h0, 0, 2, "wrap_lw3");
  endtask

  task automatic test_reset_mid;
    bit bad;
    set_word(30'h50, 32'hCAFE_F00D);
    gnt_wait = 0;
    rv_lat = 3;
    rd = 1; wr = 0; mode = 2'd2; uns = 0; addr = 32'h140;
    repeat (2) @(posedge clk);
    #2;
    rst = 1;
    rd = 0;
    #1;
    n_cmp++;
    if ({stall, done, mem_req} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_mid ctrl: got %b, want 000",
               {stall, done, mem_req});
    end
    @(posedge clk);
    #2;
    rst = 0;
    bad = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || mem_req !== 1'b0 || stall !== 1'b0) bad = 1;
    end
    n_cmp++;
    if (bad || rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_mid late_rvalid: activity or rdata %h, want 0",
               rdata);
    end
    run_op(1, 0, 2'd2, 0, 32'h140, 32'h0, 0, 1, "rst_mid_lw");
  endtask

  task automatic test_random;
    logic r, w, u;
    logic [1:0] m;
    logic [31:0] a, wd;
    for (int wa = 32'h400; wa < 32'h420; wa++)
      set_word(30'(wa), $urandom);
    for (int k = 0; k < 60; k++) begin
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      if (!r && !w) r = 1;
      m = 2'($urandom_range(0, 3));
      u = 1'($urandom_range(0, 1));
      a = 32'h1000 + $urandom_range(0, 120);
      wd = $urandom;
      run_op(r, w, m, u, a, wd, $urandom_range(0, 2),
             $urandom_range(1, 3), $sformatf("rand%0d", k));
    end
  endtask

  initial begin
    test_reset();
    test_aligned_lw();
    test_lb_lbu();
    test_split_sw();
    test_split_lh();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
